// File: rtl/bsg_ruche_stage_cell.sv
// Ruche-link stage cell: buf/inv repeater on one ruche hop plus reset/fan-out pipeline chain.
// Latency: link_i->link_o combinational; pipe_i->pipe_o exactly num_stages_p cycles.
// Backpressure: none; free-running, one word per cycle, never stalls.
module bsg_ruche_stage_cell #(
   parameter int width_p        = 32,
   parameter int ruche_factor_p = 3,
   parameter int stage_idx_p    = 0,
   parameter int edge_p         = 0,
   parameter int num_stages_p   = 2,
   parameter int harden_p       = 0
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] pipe_i,
   output logic [width_p-1:0] pipe_o,
   input  logic [width_p-1:0] link_i,
   output logic [width_p-1:0] link_o,
   output logic               invert_o
);

   // Reject illegal configurations at elaboration time.
   generate
      if (width_p < 1 || ruche_factor_p < 1 || stage_idx_p < 0 ||
          stage_idx_p >= ruche_factor_p || num_stages_p < 0) begin : g_param_err
         $error("bsg_ruche_stage_cell: illegal parameters width_p=%0d ruche_factor_p=%0d stage_idx_p=%0d num_stages_p=%0d",
                width_p, ruche_factor_p, stage_idx_p, num_stages_p);
      end
   endgenerate

   // Polarity is fixed by where this hop sits in the ruche ring. Inner hops
   // invert except the stage-0 hop of an odd ruche factor; edge hops are
   // chosen so the signal arrives at the external port in true polarity.
   localparam bit rf_even_lp   = (ruche_factor_p % 2) == 0;
   localparam bit edge_inv_lp  = (stage_idx_p > 0) &&
                                 ((stage_idx_p % 2) == (rf_even_lp ? 1 : 0));
   localparam bit inner_inv_lp = (stage_idx_p > 0) || rf_even_lp;
   localparam bit invert_lp    = (edge_p != 0) ? edge_inv_lp : inner_inv_lp;

   assign invert_o = invert_lp;

   // Repeater: XOR with the polarity constant yields a plain buffer or inverter.
   // The hardened branch is kept in its own named scope so the backend can
   // bind it to dedicated buf/inv cells; its function is identical.
   generate
      if (harden_p != 0) begin : g_hard
         assign link_o = link_i ^ {width_p{invert_lp}};
      end else begin : g_soft
         assign link_o = link_i ^ {width_p{invert_lp}};
      end
   endgenerate

   // Pipeline chain: a pure wire when no stages are requested.
   generate
      if (num_stages_p == 0) begin : g_bypass
         assign pipe_o = pipe_i;
      end else begin : g_pipe
         logic [width_p-1:0] stage_r [num_stages_p];

         // Shift register; synchronous reset flushes every in-flight word.
         always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
               for (int k = 0; k < num_stages_p; k++) stage_r[k] <= '0;
            end else begin
               stage_r[0] <= pipe_i;
               for (int k = 1; k < num_stages_p; k++) stage_r[k] <= stage_r[k-1];
            end
         end

         assign pipe_o = stage_r[num_stages_p-1];
      end
   endgenerate

endmodule

// File: tb/tb_bsg_ruche_stage_cell.sv
// Bench for bsg_ruche_stage_cell: repeater polarity across configurations,
// 2/3/0-stage pipeline latency, reset flush and reset independence of the link.
// Scoreboard queues hold expected pipeline outputs, pushed at each sampling edge.
module tb_bsg_ruche_stage_cell;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] pipe_i = '0;
   logic [31:0] link_i = '0;

   always #5 clk = ~clk;

   // u_a: rf3 inner stage0, 2 stages.  u_b: rf3 inner stage1, 3 stages.
   // u_c: rf4 inner stage0, no stages.
   logic [31:0] pipe_a, pipe_b, pipe_c, link_a, link_b, link_c;
   logic        inv_a, inv_b, inv_c;

   bsg_ruche_stage_cell #(.width_p(32), .ruche_factor_p(3), .stage_idx_p(0), .edge_p(0),
                          .num_stages_p(2), .harden_p(0)) u_a (
      .clk_i(clk), .reset_n_i(reset_n), .pipe_i(pipe_i), .pipe_o(pipe_a),
      .link_i(link_i), .link_o(link_a), .invert_o(inv_a));

   bsg_ruche_stage_cell #(.width_p(32), .ruche_factor_p(3), .stage_idx_p(1), .edge_p(0),
                          .num_stages_p(3), .harden_p(1)) u_b (
      .clk_i(clk), .reset_n_i(reset_n), .pipe_i(pipe_i), .pipe_o(pipe_b),
      .link_i(link_i), .link_o(link_b), .invert_o(inv_b));

   bsg_ruche_stage_cell #(.width_p(32), .ruche_factor_p(4), .stage_idx_p(0), .edge_p(0),
                          .num_stages_p(0), .harden_p(0)) u_c (
      .clk_i(clk), .reset_n_i(reset_n), .pipe_i(pipe_i), .pipe_o(pipe_c),
      .link_i(link_i), .link_o(link_c), .invert_o(inv_c));

   // Edge hops for ruche factors 3 and 4, every stage index.
   logic [31:0] link_e3 [3];
   logic [31:0] pipe_e3 [3];
   logic        inv_e3  [3];
   logic [31:0] link_e4 [4];
   logic [31:0] pipe_e4 [4];
   logic        inv_e4  [4];

   for (genvar i = 0; i < 3; i++) begin : g_e3
      bsg_ruche_stage_cell #(.width_p(32), .ruche_factor_p(3), .stage_idx_p(i), .edge_p(1),
                             .num_stages_p(0), .harden_p(0)) u_e (
         .clk_i(clk), .reset_n_i(reset_n), .pipe_i(pipe_i), .pipe_o(pipe_e3[i]),
         .link_i(link_i), .link_o(link_e3[i]), .invert_o(inv_e3[i]));
   end
   for (genvar i = 0; i < 4; i++) begin : g_e4
      bsg_ruche_stage_cell #(.width_p(32), .ruche_factor_p(4), .stage_idx_p(i), .edge_p(1),
                             .num_stages_p(0), .harden_p(0)) u_e (
         .clk_i(clk), .reset_n_i(reset_n), .pipe_i(pipe_i), .pipe_o(pipe_e4[i]),
         .link_i(link_i), .link_o(link_e4[i]), .invert_o(inv_e4[i]));
   end

   int n_pass  = 0;
   int n_total = 0;

   // Scoreboards: one entry per word in flight; front is what pipe_o shows.
   logic [31:0] q_a [$];
   logic [31:0] q_b [$];

   // Advance one clock edge and record what each pipeline must now present.
   task automatic tick();
      @(posedge clk);
      if (!reset_n) begin
         q_a = {};
         q_b = {};
         repeat (2) q_a.push_back(32'h0);
         repeat (3) q_b.push_back(32'h0);
      end else begin
         q_a.push_back(pipe_i);
         q_b.push_back(pipe_i);
         if (q_a.size() > 2) void'(q_a.pop_front());
         if (q_b.size() > 3) void'(q_b.pop_front());
      end
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      pipe_i  = 32'h1234_5678;
      tick();
      tick();
      n_total++;
      if (pipe_a !== 32'h0) $display("FAIL reset_pipe2 got=%h want=%h", pipe_a, 32'h0);
      else n_pass++;
      n_total++;
      if (pipe_b !== 32'h0) $display("FAIL reset_pipe3 got=%h want=%h", pipe_b, 32'h0);
      else n_pass++;
      n_total++;
      if (pipe_c !== 32'h1234_5678) $display("FAIL reset_bypass got=%h want=%h", pipe_c, 32'h1234_5678);
      else n_pass++;
   endtask

   task automatic test_pipe_seq();
      logic [31:0] stim    [4];
      logic [31:0] exp_seq [4];
      stim    = '{32'd1, 32'd2, 32'd3, 32'd0};
      exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3};
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pipe_i = stim[i];
         tick();
         n_total++;
         if (pipe_a !== exp_seq[i]) $display("FAIL pipe2_seq[%0d] got=%h want=%h", i, pipe_a, exp_seq[i]);
         else n_pass++;
         n_total++;
         if (pipe_b !== q_b[0]) $display("FAIL pipe3_seq[%0d] got=%h want=%h", i, pipe_b, q_b[0]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         pipe_i = $urandom;
         #1;
         n_total++;
         if (pipe_c !== pipe_i) $display("FAIL bypass_b2b[%0d] got=%h want=%h", i, pipe_c, pipe_i);
         else n_pass++;
         tick();
         n_total++;
         if (pipe_a !== q_a[0]) $display("FAIL pipe2_b2b[%0d] got=%h want=%h", i, pipe_a, q_a[0]);
         else n_pass++;
         n_total++;
         if (pipe_b !== q_b[0]) $display("FAIL pipe3_b2b[%0d] got=%h want=%h", i, pipe_b, q_b[0]);
         else n_pass++;
      end
   endtask

   task automatic test_midstream_reset();
      logic [31:0] first_word;
      for (int i = 0; i < 5; i++) begin
         pipe_i = 32'hC000_0000 | i;
         tick();
      end
      // One-edge reset pulse while words are in flight.
      reset_n = 1'b0;
      pipe_i  = 32'hBAD0_BAD0;
      tick();
      n_total++;
      if (pipe_b !== 32'h0) $display("FAIL midreset_flush3 got=%h want=%h", pipe_b, 32'h0);
      else n_pass++;
      n_total++;
      if (pipe_a !== 32'h0) $display("FAIL midreset_flush2 got=%h want=%h", pipe_a, 32'h0);
      else n_pass++;
      reset_n    = 1'b1;
      first_word = 32'h1111_0001;
      for (int i = 0; i < 5; i++) begin
         pipe_i = first_word + i;
         tick();
         n_total++;
         if (i < 2) begin
            if (pipe_b !== 32'h0) $display("FAIL midreset_hold3[%0d] got=%h want=%h", i, pipe_b, 32'h0);
            else n_pass++;
         end else begin
            if (pipe_b !== first_word + (i - 2)) $display("FAIL midreset_resume3[%0d] got=%h want=%h", i, pipe_b, first_word + (i - 2));
            else n_pass++;
         end
         n_total++;
         if (pipe_a !== q_a[0]) $display("FAIL midreset_pipe2[%0d] got=%h want=%h", i, pipe_a, q_a[0]);
         else n_pass++;
      end
   endtask

   task automatic test_link_inner();
      link_i = 32'hA5A5_0F0F;
      #1;
      n_total++;
      if (link_a !== 32'hA5A5_0F0F || inv_a !== 1'b0) $display("FAIL link_rf3_s0 got=%h/%b want=%h/%b", link_a, inv_a, 32'hA5A5_0F0F, 1'b0);
      else n_pass++;
      n_total++;
      if (link_b !== 32'h5A5A_F0F0 || inv_b !== 1'b1) $display("FAIL link_rf3_s1 got=%h/%b want=%h/%b", link_b, inv_b, 32'h5A5A_F0F0, 1'b1);
      else n_pass++;
      link_i = 32'h0000_0001;
      #1;
      n_total++;
      if (link_c !== 32'hFFFF_FFFE || inv_c !== 1'b1) $display("FAIL link_rf4_s0 got=%h/%b want=%h/%b", link_c, inv_c, 32'hFFFF_FFFE, 1'b1);
      else n_pass++;
   endtask

   task automatic test_link_edge();
      logic exp3 [3];
      logic exp4 [4];
      exp3 = '{1'b0, 1'b0, 1'b1};
      exp4 = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int v = 0; v < 3; v++) begin
         link_i = $urandom;
         #1;
         for (int i = 0; i < 3; i++) begin
            n_total++;
            if (inv_e3[i] !== exp3[i] || link_e3[i] !== (exp3[i] ? ~link_i : link_i))
               $display("FAIL edge_rf3_s%0d got=%h/%b want=%h/%b", i, link_e3[i], inv_e3[i], exp3[i] ? ~link_i : link_i, exp3[i]);
            else n_pass++;
         end
         for (int i = 0; i < 4; i++) begin
            n_total++;
            if (inv_e4[i] !== exp4[i] || link_e4[i] !== (exp4[i] ? ~link_i : link_i))
               $display("FAIL edge_rf4_s%0d got=%h/%b want=%h/%b", i, link_e4[i], inv_e4[i], exp4[i] ? ~link_i : link_i, exp4[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_independence();
      reset_n = 1'b0;
      link_i  = 32'h3C3C_9696;
      pipe_i  = 32'hDEAD_BEEF;
      #1;
      n_total++;
      if (link_b !== 32'hC3C3_6969) $display("FAIL link_in_reset got=%h want=%h", link_b, 32'hC3C3_6969);
      else n_pass++;
      n_total++;
      if (pipe_c !== 32'hDEAD_BEEF) $display("FAIL bypass_in_reset got=%h want=%h", pipe_c, 32'hDEAD_BEEF);
      else n_pass++;
      tick();
      n_total++;
      if (link_a !== 32'h3C3C_9696 || pipe_c !== 32'hDEAD_BEEF)
         $display("FAIL reset_edge_comb got=%h/%h want=%h/%h", link_a, pipe_c, 32'h3C3C_9696, 32'hDEAD_BEEF);
      else n_pass++;
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      test_reset();
      test_pipe_seq();
      test_back_to_back();
      test_midstream_reset();
      test_link_inner();
      test_link_edge();
      test_reset_independence();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
